// File: rtl/tdp_ram_stream_reader_if.sv
// Command, RAM port-B and output-stream signals of the stream reader in one bundle.
// master = the reader itself, slave = the command issuer / RAM / stream consumer side.
interface tdp_ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 9
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [CNT_WIDTH-1:0]  num_words;
  logic                  busy;
  logic                  done;

  logic                  mem_en;
  logic                  mem_regce;
  logic                  mem_web;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  start, base_addr, num_words, mem_rdata, m_ready,
    output busy, done, mem_en, mem_regce, mem_web, mem_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, num_words, mem_rdata, m_ready,
    input  busy, done, mem_en, mem_regce, mem_web, mem_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/tdp_ram_stream_reader.sv
// Streams num_words RAM words from base_addr; first word valid 2+READ_LATENCY cycles after start.
// Reads issue only while FIFO + in-flight occupancy leaves room, so m_ready backpressure never drops data.
module tdp_ram_stream_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tdp_ram_stream_reader_if.master io_bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] ONE_C   = OCC_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [CNT_WIDTH-1:0]    r_rem;
  logic                    r_done;
  logic [READ_LATENCY-1:0] r_pv;
  logic [READ_LATENCY-1:0] r_pl;
  logic [OCC_W-1:0]        r_inflight;
  logic [DATA_WIDTH:0]     r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wptr;
  logic [PTR_W-1:0]        r_rptr;
  logic [OCC_W-1:0]        r_count;

  logic                    w_issue;
  logic                    w_is_last;
  logic                    w_wr;
  logic                    w_wr_last;
  logic                    w_empty;
  logic                    w_rd;
  logic [DATA_WIDTH:0]     w_head;

  // Credit check uses registered counts only; the read issued this cycle is not yet counted.
  assign w_issue   = (r_state == S_ISSUE) && ((r_count + r_inflight) < DEPTH_C);
  assign w_is_last = (r_rem == CNT_WIDTH'(1));
  assign w_wr      = r_pv[READ_LATENCY-1];
  assign w_wr_last = r_pl[READ_LATENCY-1];
  assign w_empty   = (r_count == '0);
  assign w_rd      = io_bus.m_ready && !w_empty;
  assign w_head    = r_fifo[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            if (io_bus.num_words == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_addr  <= io_bus.base_addr;
              r_rem   <= io_bus.num_words;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_rem  <= r_rem - CNT_WIDTH'(1);
            if (w_is_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_rd && w_head[DATA_WIDTH]) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag pipe mirrors the RAM read latency so data is captured exactly when doutb is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv       <= '0;
      r_pl       <= '0;
      r_inflight <= '0;
    end else begin
      r_pv[0] <= w_issue;
      r_pl[0] <= w_issue && w_is_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
      case ({w_issue, w_wr})
        2'b10:   r_inflight <= r_inflight + ONE_C;
        2'b01:   r_inflight <= r_inflight - ONE_C;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_fifo[r_wptr] <= {w_wr_last, io_bus.mem_rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.done      = r_done;
  assign io_bus.mem_en    = w_issue;
  assign io_bus.mem_regce = 1'b1;
  assign io_bus.mem_web   = 1'b0;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.m_valid   = !w_empty;
  assign io_bus.m_data    = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign io_bus.m_last    = !w_empty && w_head[DATA_WIDTH];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wr && !w_rd && (r_count == DEPTH_C)));
  a_inflight_bound: assert property (@(posedge clk) disable iff (!rst_n)
    ((r_count + r_inflight) <= DEPTH_C));
endmodule
